// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: moves one LANES x LANE_W vector between a scalar-word
// memory port (one lane per cycle) and a register-file write port.
module vector_load_store_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [2:0]              vreg,
    input  logic [LANES*LANE_W-1:0] st_data,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    rf_wr_en,
    output logic [2:0]              rf_wr_dst,
    output logic [LANES*LANE_W-1:0] rf_wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int VW = LANES * LANE_W;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ISSUE = 3'd1,
        S_LD_DRAIN = 3'd2,
        S_LD_WB    = 3'd3,
        S_ST_ISSUE = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    function automatic logic [LANE_W-1:0] lane_sel(input logic [VW-1:0] vec,
                                                   input logic [IW-1:0] idx);
        lane_sel = vec[int'(idx)*LANE_W +: LANE_W];
    endfunction

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic [2:0]          r_vreg;
    logic [VW-1:0]       r_st_data;
    logic [VW-1:0]       r_vec;
    logic                r_rd_valid;
    logic [IW-1:0]       r_cap_idx;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_rd_en;
    logic                r_mem_wr_en;
    logic [LANE_W-1:0]   r_mem_wdata;
    logic                r_rf_wr_en;
    logic [2:0]          r_rf_wr_dst;
    logic [VW-1:0]       r_rf_wr_data;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [IW-1:0]       w_idx_inc;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [2:0]          w_vreg_nxt;
    logic [VW-1:0]       w_st_data_nxt;
    logic [VW-1:0]       w_vec_cap;
    logic [VW-1:0]       w_vec_nxt;
    logic                w_rd_valid_nxt;
    logic [IW-1:0]       w_cap_idx_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic                w_mem_rd_en_nxt;
    logic                w_mem_wr_en_nxt;
    logic [LANE_W-1:0]   w_mem_wdata_nxt;
    logic                w_rf_wr_en_nxt;
    logic [2:0]          w_rf_wr_dst_nxt;
    logic [VW-1:0]       w_rf_wr_data_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    assign w_idx_inc = r_idx + ONE_IDX;

    // Read data arrives one cycle after its strobe; merge it into the lane that strobe addressed.
    always_comb begin
        w_vec_cap = r_vec;
        if (r_rd_valid) begin
            w_vec_cap[int'(r_cap_idx)*LANE_W +: LANE_W] = mem_rdata;
        end else begin
            w_vec_cap = r_vec;
        end
    end

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_base_nxt       = r_base;
        w_vreg_nxt       = r_vreg;
        w_st_data_nxt    = r_st_data;
        w_vec_nxt        = w_vec_cap;
        w_rd_valid_nxt   = r_mem_rd_en;
        w_cap_idx_nxt    = r_idx;
        w_mem_addr_nxt   = '0;
        w_mem_rd_en_nxt  = 1'b0;
        w_mem_wr_en_nxt  = 1'b0;
        w_mem_wdata_nxt  = '0;
        w_rf_wr_en_nxt   = 1'b0;
        w_rf_wr_dst_nxt  = 3'd0;
        w_rf_wr_data_nxt = '0;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt     = base_addr;
                    w_vreg_nxt     = vreg;
                    w_st_data_nxt  = st_data;
                    w_idx_nxt      = '0;
                    w_vec_nxt      = '0;
                    w_mem_addr_nxt = base_addr;
                    if (op_store) begin
                        w_state_nxt     = S_ST_ISSUE;
                        w_mem_wr_en_nxt = 1'b1;
                        w_mem_wdata_nxt = lane_sel(st_data, '0);
                    end else begin
                        w_state_nxt     = S_LD_ISSUE;
                        w_mem_rd_en_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LD_ISSUE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_LD_DRAIN;
                end else begin
                    w_idx_nxt       = w_idx_inc;
                    w_mem_rd_en_nxt = 1'b1;
                    w_mem_addr_nxt  = r_base + ADDR_W'(w_idx_inc);
                end
            end
            S_LD_DRAIN: begin
                // The last lane lands this cycle, so write back the merged vector directly.
                w_state_nxt      = S_LD_WB;
                w_rf_wr_en_nxt   = 1'b1;
                w_rf_wr_dst_nxt  = r_vreg;
                w_rf_wr_data_nxt = w_vec_cap;
            end
            S_LD_WB: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            S_ST_ISSUE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt       = w_idx_inc;
                    w_mem_wr_en_nxt = 1'b1;
                    w_mem_addr_nxt  = r_base + ADDR_W'(w_idx_inc);
                    w_mem_wdata_nxt = lane_sel(r_st_data, w_idx_inc);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, latched request and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_base       <= '0;
            r_vreg       <= 3'd0;
            r_st_data    <= '0;
            r_vec        <= '0;
            r_rd_valid   <= 1'b0;
            r_cap_idx    <= '0;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wdata  <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_dst  <= 3'd0;
            r_rf_wr_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_base       <= w_base_nxt;
            r_vreg       <= w_vreg_nxt;
            r_st_data    <= w_st_data_nxt;
            r_vec        <= w_vec_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_cap_idx    <= w_cap_idx_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rd_en  <= w_mem_rd_en_nxt;
            r_mem_wr_en  <= w_mem_wr_en_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rf_wr_en   <= w_rf_wr_en_nxt;
            r_rf_wr_dst  <= w_rf_wr_dst_nxt;
            r_rf_wr_data <= w_rf_wr_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_wr_en  = r_mem_wr_en;
    assign mem_wdata  = r_mem_wdata;
    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_dst  = r_rf_wr_dst;
    assign rf_wr_data = r_rf_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Table-driven bench for vector_load_store_unit with a 64K-word memory model
// and cycle-exact checks of every output during each operation.
module tb_vector_load_store_unit;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_store;
    logic [15:0]   base_addr;
    logic [2:0]    vreg;
    logic [255:0]  st_data;
    logic [15:0]   mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = 16'hDEAD;
    logic          rf_wr_en;
    logic [2:0]    rf_wr_dst;
    logic [255:0]  rf_wr_data;
    logic          busy;
    logic          done;

    int nvec  = 0;
    int nfail = 0;

    vector_load_store_unit #(.LANES(16), .LANE_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_store   (op_store),
        .base_addr  (base_addr),
        .vreg       (vreg),
        .st_data    (st_data),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_dst  (rf_wr_dst),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pre(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // Memory model: preloaded on the first edge, one-cycle read latency.
    logic [15:0] mem [0:65535];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < 65536; a++) mem[a] = pre(16'(a));
            for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
            mem_loaded = 1'b1;
        end else begin
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
            else           mem_rdata <= 16'hDEAD;
            if (mem_wr_en) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic chk(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle T+%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Starts an operation at the current negedge and checks every output through the idle cycle after done.
    task automatic run_op(input logic st, input logic [15:0] base, input logic [2:0] vr,
                          input logic [255:0] sd, input logic [255:0] exp_rf, input logic glitch);
        int last;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_act;
        last = st ? 17 : 19;
        start = 1'b1; op_store = st; base_addr = base; vreg = vr; st_data = sd;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            e_act   = (k <= 16);
            e_addr  = e_act ? base + 16'(k - 1) : 16'h0000;
            e_wdata = (st && e_act) ? sd[16*(k-1) +: 16] : 16'h0000;
            chk("mem_rd_en", k, 256'(mem_rd_en), 256'(!st && e_act));
            chk("mem_wr_en", k, 256'(mem_wr_en), 256'(st && e_act));
            chk("mem_addr",  k, 256'(mem_addr),  256'(e_addr));
            chk("mem_wdata", k, 256'(mem_wdata), 256'(e_wdata));
            chk("rf_wr_en",  k, 256'(rf_wr_en),  256'(!st && k == 18));
            if (!st && k == 18) begin
                chk("rf_wr_dst",  k, 256'(rf_wr_dst), 256'(vr));
                chk("rf_wr_data", k, rf_wr_data, exp_rf);
            end
            chk("done", k, 256'(done), 256'(k == last));
            chk("busy", k, 256'(busy), 256'(k <= last));
            if (k == 1) begin
                start = 1'b0; st_data = ~sd; base_addr = ~base;
            end
            if (glitch && k == 5) begin
                start = 1'b1; op_store = 1'b0; st_data = ~sd; base_addr = base ^ 16'h0F0F;
            end
            if (glitch && k == 6) start = 1'b0;
        end
    endtask

    typedef struct {
        logic         op_store;
        logic [15:0]  base;
        logic [2:0]   vreg;
        logic [255:0] st_data;
        logic [255:0] exp_rf;
        logic         glitch;
    } vec_t;

    vec_t tbl [8];

    task automatic chk_all_zero(input int k);
        chk("rst_rd_en",  k, 256'(mem_rd_en), 256'(0));
        chk("rst_wr_en",  k, 256'(mem_wr_en), 256'(0));
        chk("rst_addr",   k, 256'(mem_addr),  256'(0));
        chk("rst_wdata",  k, 256'(mem_wdata), 256'(0));
        chk("rst_rf_en",  k, 256'(rf_wr_en),  256'(0));
        chk("rst_rf_dst", k, 256'(rf_wr_dst), 256'(0));
        chk("rst_rf_dat", k, rf_wr_data,      256'(0));
        chk("rst_done",   k, 256'(done),      256'(0));
        chk("rst_busy",   k, 256'(busy),      256'(0));
    endtask

    initial begin
        logic [255:0] v_a, v_pre, v_1111, v_st3, v_st5;
        for (int i = 0; i < 16; i++) begin
            v_a[16*i +: 16]    = 16'hA000 + 16'(i);
            v_pre[16*i +: 16]  = pre(16'hFFF8 + 16'(i));
            v_1111[16*i +: 16] = 16'(i * 16'h1111);
            v_st3[16*i +: 16]  = 16'h0F0F ^ 16'(i * 16'h0101);
            v_st5[16*i +: 16]  = 16'h8000 | 16'(i * 7);
        end
        tbl[0] = '{1'b0, 16'h0100, 3'd5, 256'(0), v_a,    1'b0};
        tbl[1] = '{1'b1, 16'h2000, 3'd4, v_1111,  256'(0), 1'b0};
        tbl[2] = '{1'b0, 16'hFFF8, 3'd2, 256'(0), v_pre,  1'b0};
        tbl[3] = '{1'b1, 16'h3000, 3'd6, v_st3,   256'(0), 1'b1};
        tbl[4] = '{1'b0, 16'h3000, 3'd7, 256'(0), v_st3,  1'b0};
        tbl[5] = '{1'b1, 16'hFFFC, 3'd1, v_st5,   256'(0), 1'b0};
        tbl[6] = '{1'b0, 16'hFFFC, 3'd1, 256'(0), v_st5,  1'b0};
        tbl[7] = '{1'b0, 16'h2000, 3'd0, 256'(0), v_1111, 1'b0};

        rst = 1'b1; start = 1'b0; op_store = 1'b0; base_addr = 16'h0000; vreg = 3'd0; st_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero(0);
        rst = 1'b0;

        for (int n = 0; n < 8; n++)
            run_op(tbl[n].op_store, tbl[n].base, tbl[n].vreg, tbl[n].st_data, tbl[n].exp_rf, tbl[n].glitch);

        // Mid-load reset: abandon, then a fresh load must complete normally.
        start = 1'b1; op_store = 1'b0; base_addr = 16'h0100; vreg = 3'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("pre_rst_rd_en", 10, 256'(mem_rd_en), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero(11);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero(12);
        run_op(1'b0, 16'h0100, 3'd3, 256'(0), v_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vector_load_store_unit.md
VECTOR_LOAD_STORE_UNIT -- requirements
Module: vector_load_store_unit

Interface
REQ-001 SHALL have parameter LANES, default 16, giving the number of lanes per vector.
REQ-002 SHALL have parameter LANE_W, default 16, giving the bits per lane; vector width VW = LANES*LANE_W = 256.
REQ-003 SHALL have parameter ADDR_W, default 16, giving the memory word-address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-007 SHALL have port op_store, input, 1: 0 = vector load, 1 = vector store; sampled with start.
REQ-008 SHALL have port base_addr, input, ADDR_W, the word address of lane 0; sampled with start.
REQ-009 SHALL have port vreg, input, 3, the destination register for loads; sampled with start.
REQ-010 SHALL have port st_data, input, VW, store vector from a register-file read port; sampled with start.
REQ-011 SHALL have port mem_addr, output, ADDR_W, the memory word address.
REQ-012 SHALL have port mem_rd_en, output, 1, the memory read strobe.
REQ-013 SHALL have port mem_wr_en, output, 1, the memory write strobe.
REQ-014 SHALL have port mem_wdata, output, LANE_W, the memory write data.
REQ-015 SHALL have port mem_rdata, input, LANE_W, read data, valid the cycle after mem_rd_en.
REQ-016 SHALL have ports rf_wr_en (1), rf_wr_dst (3) and rf_wr_data (VW), outputs forming the register-file write port.
REQ-017 SHALL have ports busy (1) and done (1), outputs; done is a one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, LD_ISSUE, LD_DRAIN, LD_WB, ST_ISSUE and DONE, with a lane counter i in 0..LANES-1.
REQ-019 SHALL, in IDLE with start=1 at edge T, latch all request inputs, clear i, and enter LD_ISSUE (op_store=0) or ST_ISSUE (op_store=1).
REQ-020 SHALL map lane i to rf/st bits [LANE_W*i+LANE_W-1 : LANE_W*i] and to address (base_addr+i) mod 2^ADDR_W, wrapping silently.
REQ-021 SHALL, in LD_ISSUE, assert mem_rd_en with mem_addr = base+i during cycle T+1+i for i = 0..15, then enter LD_DRAIN.
REQ-022 SHALL capture mem_rdata into lane i of an internal vector at the end of cycle T+2+i; LD_DRAIN lasts exactly one cycle (T+17) and captures lane 15.
REQ-023 SHALL, in LD_WB (cycle T+18), assert rf_wr_en=1, rf_wr_dst=vreg and rf_wr_data=assembled vector for exactly one cycle.
REQ-024 SHALL, in ST_ISSUE, assert mem_wr_en with mem_addr = base+i and mem_wdata = lane i of the latched st_data during cycle T+1+i, for i = 0..15.
REQ-025 SHALL, in DONE, pulse done=1 for one cycle, then return to IDLE; load done is at T+19 and store done at T+17.
REQ-026 SHALL hold busy=1 in every state except IDLE.
REQ-027 SHALL ignore start while busy=1; no queuing.
REQ-028 SHALL never assert mem_rd_en and mem_wr_en in the same cycle, and never assert rf_wr_en during a store.
REQ-029 SHALL accept a new start in the cycle after DONE.
REQ-030 SHALL drive mem_addr=0 and mem_wdata=0 whenever no strobe is asserted.

Reset
REQ-031 SHALL, when rst=1 at an edge, enter IDLE, clear i and all latched data, and drive every output to 0 from the next cycle.
REQ-032 SHALL take reset priority over start and over any operation in progress.
REQ-033 SHALL, on a mid-operation reset, abandon the operation with no rf_wr_en and no done pulse, and deassert strobes from the next cycle.

Verification
REQ-034 SHALL pass this test: load with base=0x0100, vreg=5, memory[0x0100+i]=0xA000+i -> reads at 0x0100..0x010F in T+1..T+16; rf_wr_en at T+18 with dst=5 and lane i=0xA000+i; done at T+19.
REQ-035 SHALL pass this test: store with base=0x2000, st_data lane i=0x1111*i -> 16 writes at 0x2000..0x200F in T+1..T+16 with mem_wdata=0x1111*i; done at T+17; rf_wr_en stays 0.
REQ-036 SHALL pass this test: load with base=0xFFF8 -> addresses 0xFFF8..0xFFFF, then 0x0000..0x0007; lane order preserved.
REQ-037 SHALL pass this test: start pulsed at T+5 during a store with different st_data -> ignored; written data unchanged; exactly one done.
REQ-038 SHALL pass this test: rst at T+10 of a load -> strobes 0 and busy=0 from T+11; no rf_wr_en or done; a new load started at T+12 completes correctly.
REQ-039 SHALL pass this test: a back-to-back store then load using the same address -> the load returns the stored values; no cycle has both memory strobes high.
